core_inst_sequencer: RTL and testbench

//  Upstream controller for one attention core: generates the 17-bit inst word plus acc/div strobes for a full pass:

---
 rtl/core_seq_pkg.sv | 47 ++++
 rtl/core_inst_pack.sv | 24 ++
 rtl/core_inst_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_core_inst_sequencer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/core_seq_pkg.sv
// Shared types and inst-word field positions for the attention-core sequencer.
// Optional normalization states exist only when CORE_SEQ_NORM_EN is defined.
package core_seq_pkg;

    localparam int unsigned INST_W = 17;
    localparam int unsigned ADDR_W = 4;
    // One bit wider than an address so EXE can count its n_q+1 cycles.
    localparam int unsigned CNT_W  = 5;

    localparam int unsigned INST_OFIFO_RD      = 16;
    localparam int unsigned INST_QKMEM_ADD_LSB = 12;
    localparam int unsigned INST_PMEM_ADD_LSB  = 8;
    localparam int unsigned INST_EXECUTE       = 7;
    localparam int unsigned INST_KERNEL_LD     = 6;
    localparam int unsigned INST_QMEM_RD       = 5;
    localparam int unsigned INST_QMEM_WR       = 4;
    localparam int unsigned INST_KMEM_RD       = 3;
    localparam int unsigned INST_KMEM_WR       = 2;
    localparam int unsigned INST_PMEM_RD       = 1;
    localparam int unsigned INST_PMEM_WR       = 0;

`ifdef CORE_SEQ_NORM_EN
    typedef enum logic [3:0] {
        StIdle, StQwr, StKwr, StKld, StGap, StExe, StDrn,
        StNrmAccRd, StNrmAccAcc, StNrmRd, StNrmDiv, StNrmWr, StDone
    } state_e;
`else
    typedef enum logic [3:0] {
        StIdle, StQwr, StKwr, StKld, StGap, StExe, StDrn, StDone
    } state_e;
`endif

    typedef struct packed {
        logic              ofifo_rd;
        logic [ADDR_W-1:0] qkmem_add;
        logic [ADDR_W-1:0] pmem_add;
        logic              execute;
        logic              kernel_ld;
        logic              qmem_rd;
        logic              qmem_wr;
        logic              kmem_rd;
        logic              kmem_wr;
        logic              pmem_rd;
        logic              pmem_wr;
    } ctrl_t;

endpackage

// File: rtl/core_inst_pack.sv
// Combinational packer from named control fields to the 17-bit core inst word.
module core_inst_pack
    import core_seq_pkg::*;
(
    input  ctrl_t              i_ctrl,
    output logic [INST_W-1:0]  o_inst
);

    always_comb begin
        o_inst = '0;
        o_inst[INST_OFIFO_RD]                     = i_ctrl.ofifo_rd;
        o_inst[INST_QKMEM_ADD_LSB +: ADDR_W]      = i_ctrl.qkmem_add;
        o_inst[INST_PMEM_ADD_LSB +: ADDR_W]       = i_ctrl.pmem_add;
        o_inst[INST_EXECUTE]                      = i_ctrl.execute;
        o_inst[INST_KERNEL_LD]                    = i_ctrl.kernel_ld;
        o_inst[INST_QMEM_RD]                      = i_ctrl.qmem_rd;
        o_inst[INST_QMEM_WR]                      = i_ctrl.qmem_wr;
        o_inst[INST_KMEM_RD]                      = i_ctrl.kmem_rd;
        o_inst[INST_KMEM_WR]                      = i_ctrl.kmem_wr;
        o_inst[INST_PMEM_RD]                      = i_ctrl.pmem_rd;
        o_inst[INST_PMEM_WR]                      = i_ctrl.pmem_wr;
    end

endmodule

// File: rtl/core_inst_sequencer.sv
// Pass sequencer for one attention core: load Q/K, kernel load, execute, drain, optional normalize.
// Build macro: CORE_SEQ_NORM_EN enables the sfp_row normalization phase.
module core_inst_sequencer
    import core_seq_pkg::*;
#(
    parameter int unsigned Col  = 8,
    parameter int unsigned NQ   = 16,
    parameter int unsigned KGap = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_fifo_valid,
    output logic              o_ld_req,
    output logic              o_ld_sel,
    output logic [ADDR_W-1:0] o_ld_idx,
    output logic [INST_W-1:0] o_inst,
    output logic              o_acc,
    output logic              o_div,
    output logic              o_busy,
    output logic              o_done
);

    localparam logic [CNT_W-1:0] CntQLast = CNT_W'(NQ - 1);
    localparam logic [CNT_W-1:0] CntQ     = CNT_W'(NQ);
    localparam logic [CNT_W-1:0] CntCLast = CNT_W'(Col - 1);
    localparam logic [CNT_W-1:0] CntC     = CNT_W'(Col);
    localparam logic [CNT_W-1:0] CntGLast = CNT_W'(KGap - 1);

    state_e             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [ADDR_W-1:0]  w_addr;
    ctrl_t              w_ctrl;
    logic [INST_W-1:0]  w_inst;
    logic               w_ld_req;
    logic               w_ld_sel;
    logic [ADDR_W-1:0]  w_ld_idx;
    logic               w_acc;
    logic               w_div;

    assign w_addr = r_cnt[ADDR_W-1:0];

    // Decode this cycle's controls from the current state; registered below.
    always_comb begin
        w_ctrl   = '0;
        w_ld_req = 1'b0;
        w_ld_sel = 1'b0;
        w_ld_idx = '0;
        w_acc    = 1'b0;
        w_div    = 1'b0;
        unique case (r_state)
            StQwr: begin
                w_ctrl.qmem_wr   = 1'b1;
                w_ctrl.qkmem_add = w_addr;
                w_ld_req         = 1'b1;
                w_ld_idx         = w_addr;
            end
            StKwr: begin
                w_ctrl.kmem_wr   = 1'b1;
                w_ctrl.qkmem_add = w_addr;
                w_ld_req         = 1'b1;
                w_ld_sel         = 1'b1;
                w_ld_idx         = w_addr;
            end
            StKld: begin
                w_ctrl.kernel_ld = 1'b1;
                if (r_cnt < CntC) begin
                    w_ctrl.kmem_rd   = 1'b1;
                    w_ctrl.qkmem_add = w_addr;
                end
            end
            StExe: begin
                w_ctrl.execute = 1'b1;
                if (r_cnt < CntQ) begin
                    w_ctrl.qmem_rd   = 1'b1;
                    w_ctrl.qkmem_add = w_addr;
                end
            end
            StDrn: begin
                if (i_fifo_valid) begin
                    w_ctrl.ofifo_rd = 1'b1;
                    w_ctrl.pmem_wr  = 1'b1;
                    w_ctrl.pmem_add = w_addr;
                end
            end
`ifdef CORE_SEQ_NORM_EN
            StNrmAccRd: begin
                w_ctrl.pmem_rd  = 1'b1;
                w_ctrl.pmem_add = w_addr;
            end
            StNrmAccAcc: w_acc = 1'b1;
            StNrmRd: begin
                w_ctrl.pmem_rd  = 1'b1;
                w_ctrl.pmem_add = w_addr;
            end
            StNrmDiv: w_div = 1'b1;
            StNrmWr: begin
                w_ctrl.pmem_wr  = 1'b1;
                w_ctrl.pmem_add = w_addr;
            end
`endif
            default: ;
        endcase
    end

    core_inst_pack u_pack (
        .i_ctrl (w_ctrl),
        .o_inst (w_inst)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= StIdle;
            r_cnt    <= '0;
            o_inst   <= '0;
            o_ld_req <= 1'b0;
            o_ld_sel <= 1'b0;
            o_ld_idx <= '0;
            o_acc    <= 1'b0;
            o_div    <= 1'b0;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
        end else begin
            o_inst   <= w_inst;
            o_ld_req <= w_ld_req;
            o_ld_sel <= w_ld_sel;
            o_ld_idx <= w_ld_idx;
            o_acc    <= w_acc;
            o_div    <= w_div;
            o_busy   <= (r_state != StIdle) && (r_state != StDone);
            o_done   <= (r_state == StDone);
            r_cnt    <= r_cnt + 1'b1;
            unique case (r_state)
                StIdle: begin
                    r_cnt <= '0;
                    if (i_start) r_state <= StQwr;
                end
                StQwr: if (r_cnt == CntQLast) begin
                    r_state <= StKwr;
                    r_cnt   <= '0;
                end
                StKwr: if (r_cnt == CntCLast) begin
                    r_state <= StKld;
                    r_cnt   <= '0;
                end
                StKld: if (r_cnt == CntC) begin
                    r_state <= (KGap == 0) ? StExe : StGap;
                    r_cnt   <= '0;
                end
                StGap: if (r_cnt == CntGLast) begin
                    r_state <= StExe;
                    r_cnt   <= '0;
                end
                StExe: if (r_cnt == CntQ) begin
                    r_state <= StDrn;
                    r_cnt   <= '0;
                end
                StDrn: begin
                    if (!i_fifo_valid) begin
                        r_cnt <= r_cnt;
                    end else if (r_cnt == CntQLast) begin
`ifdef CORE_SEQ_NORM_EN
                        r_state <= StNrmAccRd;
`else
                        r_state <= StDone;
`endif
                        r_cnt   <= '0;
                    end
                end
`ifdef CORE_SEQ_NORM_EN
                StNrmAccRd: begin
                    r_state <= StNrmAccAcc;
                    r_cnt   <= r_cnt;
                end
                StNrmAccAcc: begin
                    if (r_cnt == CntQLast) begin
                        r_state <= StNrmRd;
                        r_cnt   <= '0;
                    end else begin
                        r_state <= StNrmAccRd;
                    end
                end
                StNrmRd: begin
                    r_state <= StNrmDiv;
                    r_cnt   <= r_cnt;
                end
                StNrmDiv: begin
                    r_state <= StNrmWr;
                    r_cnt   <= r_cnt;
                end
                StNrmWr: begin
                    if (r_cnt == CntQLast) begin
                        r_state <= StDone;
                        r_cnt   <= '0;
                    end else begin
                        r_state <= StNrmRd;
                    end
                end
`endif
                StDone: begin
                    r_state <= StIdle;
                    r_cnt   <= '0;
                end
                default: begin
                    r_state <= StIdle;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_inst_sequencer.sv
// Self-checking bench for core_inst_sequencer: per-cycle trace compared against a pass model
// built from the phase rules; honours CORE_SEQ_NORM_EN for the normalization phase.
module tb_core_inst_sequencer;

    localparam int NQ     = 16;
    localparam int COL    = 8;
    localparam int KGAP   = 1;
    localparam int DRN_AT = NQ + COL + (COL + 1) + KGAP + (NQ + 1);

    typedef struct packed {
        logic [16:0] inst;
        logic        ld_req;
        logic        ld_sel;
        logic [3:0]  ld_idx;
        logic        acc;
        logic        div;
        logic        busy;
        logic        done;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        fv;
    logic        ld_req, ld_sel, acc, div, busy, done;
    logic [3:0]  ld_idx;
    logic [16:0] inst;
    obs_t        obs;

    int   n_tests = 0;
    int   n_fail  = 0;
    obs_t exp_q[$];
    bit   fv_plan[$];
    int   stall[NQ];

    always #5 clk = ~clk;

    core_inst_sequencer dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_fifo_valid (fv),
        .o_ld_req     (ld_req),
        .o_ld_sel     (ld_sel),
        .o_ld_idx     (ld_idx),
        .o_inst       (inst),
        .o_acc        (acc),
        .o_div        (div),
        .o_busy       (busy),
        .o_done       (done)
    );

    assign obs = '{inst: inst, ld_req: ld_req, ld_sel: ld_sel, ld_idx: ld_idx,
                   acc: acc, div: div, busy: busy, done: done};

    function automatic obs_t mk(input int iw, input bit lr, input bit ls, input int idx,
                                input bit a, input bit d, input bit b, input bit dn);
        obs_t o;
        o.inst   = 17'(iw);
        o.ld_req = lr;
        o.ld_sel = ls;
        o.ld_idx = 4'(idx);
        o.acc    = a;
        o.div    = d;
        o.busy   = b;
        o.done   = dn;
        return o;
    endfunction

    task automatic chk(input string tag, input int k, input obs_t o, input obs_t e);
        n_tests++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, k, o, e);
        end
    endtask

    task automatic chk_bit(input string tag, input int k, input logic o, input logic e);
        n_tests++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, k, o, e);
        end
    endtask

    // Expected output trace of one pass (one entry per clock after the start sample),
    // ending with one idle cycle. stall[r] = idle cycles before drain row r is readable.
    task automatic build_pass();
        exp_q.delete();
        fv_plan.delete();
        for (int r = 0; r < NQ; r++)  exp_q.push_back(mk((1 << 4) | (r << 12), 1, 0, r, 0, 0, 1, 0));
        for (int r = 0; r < COL; r++) exp_q.push_back(mk((1 << 2) | (r << 12), 1, 1, r, 0, 0, 1, 0));
        for (int r = 0; r <= COL; r++)
            exp_q.push_back(mk((1 << 6) | ((r < COL) ? ((1 << 3) | (r << 12)) : 0), 0, 0, 0, 0, 0, 1, 0));
        for (int r = 0; r < KGAP; r++) exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0));
        for (int r = 0; r <= NQ; r++)
            exp_q.push_back(mk((1 << 7) | ((r < NQ) ? ((1 << 5) | (r << 12)) : 0), 0, 0, 0, 0, 0, 1, 0));
        for (int r = 0; r < NQ; r++) begin
            for (int s = 0; s < stall[r]; s++) begin
                exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0));
                fv_plan.push_back(1'b0);
            end
            exp_q.push_back(mk((1 << 16) | 1 | (r << 8), 0, 0, 0, 0, 0, 1, 0));
            fv_plan.push_back(1'b1);
        end
`ifdef CORE_SEQ_NORM_EN
        for (int r = 0; r < NQ; r++) begin
            exp_q.push_back(mk(2 | (r << 8), 0, 0, 0, 0, 0, 1, 0));
            exp_q.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0));
        end
        for (int r = 0; r < NQ; r++) begin
            exp_q.push_back(mk(2 | (r << 8), 0, 0, 0, 0, 0, 1, 0));
            exp_q.push_back(mk(0, 0, 0, 0, 0, 1, 1, 0));
            exp_q.push_back(mk(1 | (r << 8), 0, 0, 0, 0, 0, 1, 0));
        end
`endif
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1));
        exp_q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    task automatic kick(input string tag);
        @(negedge clk);
        start = 1'b1;
        fv    = 1'($urandom);
        @(posedge clk);
        #1;
        chk(tag, 0, obs, mk(0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    // Drive edges k_from..k_to of the current pass and compare each cycle's outputs.
    // Outside drain fifo_valid is random; start is random (must be ignored) until the idle cycle.
    task automatic run_range(input string tag, input int k_from, input int k_to);
        for (int k = k_from; k <= k_to; k++) begin
            @(negedge clk);
            start = (k < exp_q.size()) ? 1'($urandom) : 1'b0;
            if (k - 1 >= DRN_AT && k - 1 - DRN_AT < fv_plan.size())
                fv = fv_plan[k - 1 - DRN_AT];
            else
                fv = 1'($urandom);
            @(posedge clk);
            #1;
            chk(tag, k, obs, exp_q[k - 1]);
            chk_bit("pmem_rd_wr_overlap", k, inst[1] & inst[0], 1'b0);
            chk_bit("ofifo_rd_without_valid", k, inst[16] & ~fv, 1'b0);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        fv    = 1'b0;
        #12;
        chk("reset_state", 0, obs, mk(0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_after_reset", 0, obs, mk(0, 0, 0, 0, 0, 0, 0, 0));

        // Basic pass, no drain stalls.
        for (int r = 0; r < NQ; r++) stall[r] = 0;
        build_pass();
        kick("basic_start");
        run_range("basic_pass", 1, exp_q.size());

        // Drain stall on rows 3..5, 4 cycles each.
        for (int r = 0; r < NQ; r++) stall[r] = (r >= 3 && r <= 5) ? 4 : 0;
        build_pass();
        kick("stall_start");
        run_range("stall_pass", 1, exp_q.size());

        // Random drain stalls.
        for (int p = 0; p < 3; p++) begin
            for (int r = 0; r < NQ; r++)
                stall[r] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 5)) : 0;
            build_pass();
            kick("rand_start");
            run_range("rand_pass", 1, exp_q.size());
        end

        // Asynchronous reset in the middle of EXE, then a clean restart.
        for (int r = 0; r < NQ; r++) stall[r] = 0;
        build_pass();
        kick("abort_start");
        run_range("abort_pre", 1, DRN_AT - 6);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_async_clear", 0, obs, mk(0, 0, 0, 0, 0, 0, 0, 0));
        @(negedge clk);
        start = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("abort_no_done", i, obs, mk(0, 0, 0, 0, 0, 0, 0, 0));
        end
        for (int r = 0; r < NQ; r++) stall[r] = (r == 0 || r == NQ - 1) ? 2 : 0;
        build_pass();
        kick("restart_start");
        run_range("restart_pass", 1, exp_q.size());

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
